// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and Gray-code helper for the write domain
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_SIZE_DEF = 6;
  localparam int FIFO_DEPTH = 2 ** ADDR_SIZE_DEF;
  localparam int AFULL_THRESH_DEF = 56;
  localparam int DROP_CNT_W_DEF = 16;
  function automatic logic [ADDR_SIZE_DEF:0] gray2bin_f(input logic [ADDR_SIZE_DEF:0] g);
    logic [ADDR_SIZE_DEF:0] b;
    b = '0;
    for (int i = 0; i <= ADDR_SIZE_DEF; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary pointer conversion
module gray2bin import fifo_pkg::*; #(
  parameter int WIDTH = ADDR_SIZE_DEF + 1
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress: skid-buffered write ingress with fill level and drop statistics
module fifo_wr_ingress import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int AFULL_THRESH = AFULL_THRESH_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_drop_en,
  input  logic                  clr_stats,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wfull,
  input  logic [ADDR_SIZE:0]    wptr,
  input  logic [ADDR_SIZE:0]    wq2_rptr,
  output logic [ADDR_SIZE:0]    wlevel,
  output logic                  walmost_full,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  overflow_sticky
);
  localparam int PW = ADDR_SIZE + 1;
  logic                  out_valid, skid_valid;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic                  xfer, acc, drop, out_free;
  logic [PW-1:0]         wbin, rbin, level_n;
  gray2bin #(.WIDTH(PW)) u_wbin (.gray(wptr), .bin(wbin));
  gray2bin #(.WIDTH(PW)) u_rbin (.gray(wq2_rptr), .bin(rbin));
  assign winc     = out_valid;
  assign wdata    = out_data;
  assign xfer     = out_valid & ~wfull;
  assign out_free = ~out_valid | xfer;
  assign s_ready  = s_drop_en | ~skid_valid;
  assign acc      = s_valid & ~skid_valid;
  assign drop     = s_drop_en & s_valid & skid_valid;
  assign level_n  = wbin - rbin;
  // output register: skid drains first to keep order, else a new sample, else it empties
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer & skid_valid) begin
      out_valid <= 1'b1;
      out_data  <= skid_data;
    end else if (acc & out_free) begin
      out_valid <= 1'b1;
      out_data  <= s_data;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  // skid register catches a sample when the output register stays occupied
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (acc & ~out_free) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end else if (xfer) begin
      skid_valid <= 1'b0;
    end
  // pessimistic fill level from the synchronised pointers, modular subtract handles wrap
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_n;
      walmost_full <= level_n >= PW'(AFULL_THRESH);
    end
  // drop statistics: clear wins over increment but still counts a same-cycle drop
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      drop_cnt        <= '0;
      overflow_sticky <= 1'b0;
    end else if (clr_stats) begin
      drop_cnt        <= DROP_CNT_W'(drop);
      overflow_sticky <= drop;
    end else if (drop) begin
      drop_cnt        <= (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;
      overflow_sticky <= 1'b1;
    end
endmodule

// File: doc/fifo_wr_ingress.md
Name: fifo_wr_ingress

Overview:
Write-side ingress stage that sits directly upstream of the async FIFO write-pointer/full logic in the wclk domain. It accepts 16-bit FIR samples over a valid/ready stream and buffers them in a 2-entry skid buffer. It drives winc/wdata into the FIFO and honours wfull. It also derives a registered fill level and an almost-full flag, and supports an optional drop-on-full mode with saturating drop statistics.

Parameters:
DATA_WIDTH, 16, sample width
ADDR_SIZE, 6, FIFO address bits (depth 2^ADDR_SIZE = 64); matches FIFO pointer logic
AFULL_THRESH, 56, wlevel at or above this value asserts walmost_full
DROP_CNT_W, 16, width of the saturating drop counter

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready
s_data  in  DATA_WIDTH  upstream sample
s_drop_en  in  1  1 = drop on full (s_ready forced 1); 0 = backpressure
clr_stats  in  1  synchronous clear of drop_cnt and overflow_sticky
winc  out  1  FIFO write request
wdata  out  DATA_WIDTH  FIFO write data
wfull  in  1  FIFO full flag (registered, from pointer logic)
wptr  in  ADDR_SIZE+1  FIFO write pointer, Gray code
wq2_rptr  in  ADDR_SIZE+1  read pointer synchronised into wclk, Gray code
wlevel  out  ADDR_SIZE+1  registered conservative fill level
walmost_full  out  1  registered, wlevel >= AFULL_THRESH
drop_cnt  out  DROP_CNT_W  saturating count of dropped samples
overflow_sticky  out  1  set on any drop; cleared only by clr_stats or reset

Behaviour:
- Reset (async, wrst_n=0) clears out_valid, skid_valid, wdata, wlevel, walmost_full, drop_cnt and overflow_sticky to 0. With skid_valid=0, s_ready reads 1.
- Storage is an output register (out_valid/out_data) plus a skid register (skid_valid/skid_data).
- Signals:
  - winc = out_valid; wdata = out_data.
  - xfer = out_valid & ~wfull. This is the FIFO-side transfer and matches the pointer logic's gating.
  - s_ready = s_drop_en | ~skid_valid. Combinational from registers and mode input only; no dependence on s_valid.
  - acc = s_valid & ~skid_valid is an accepted sample.
- Accepted-sample placement:
  - If the output register is free after this cycle (~out_valid or xfer) and the skid register is empty, acc loads the output register.
  - Otherwise acc loads the skid register.
- On xfer with skid_valid=1, skid moves to the output register the same edge, and skid_valid clears unless a new acc refills it.
- Latency: a sample accepted at edge N is on wdata with winc=1 after edge N. FIFO order is strictly preserved. Sustained throughput is 1 sample/cycle while ~wfull.
- Drop mode: when s_drop_en=1, s_valid=1 and skid_valid=1, the sample is discarded.
  - drop_cnt increments, saturating at all-ones.
  - overflow_sticky is set.
  - Buffered samples are never overwritten.
- clr_stats has priority over increments. A drop in the same cycle as clr_stats gives drop_cnt=1 and overflow_sticky=1.
- Level:
  - wbin = gray2bin(wptr) and rbin = gray2bin(wq2_rptr).
  - wlevel <= (wbin - rbin) mod 2^(ADDR_SIZE+1), registered one cycle.
  - The value is pessimistic (reads visible 2+ cycles late) and never under-reports occupancy. Pointer wrap is handled by the modular subtract.
- walmost_full <= (next wlevel >= AFULL_THRESH), registered in the same cycle as wlevel.
- Toggling s_drop_en mid-stream takes effect the same cycle and does not disturb buffered data.
- wfull held high keeps winc=1 and wdata stable until the FIFO accepts the sample.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDR_SIZE and DATA_WIDTH defaults
  - FIFO_DEPTH = 2**ADDR_SIZE
  - a Gray-to-binary function width-parameterised on ADDR_SIZE+1
- One sub-module is natural: gray2bin (combinational, parameter WIDTH), instantiated twice for wptr and wq2_rptr.

Test Plan:
- Reset mid-stream with out_valid=skid_valid=1 and drop_cnt=5 -> all outputs 0, s_ready=1, wlevel=0 immediately (async).
- Single sample 0x1234 accepted at edge N, wfull=0 -> winc=1, wdata=0x1234 after N. winc=0 after N+1. wlevel=1 one cycle after wptr advances.
- Reader stalled, s_drop_en=0, 70 back-to-back samples 0..69:
  - 64 written, then wfull=1; samples 64 and 65 held in the buffer; s_ready=0; drop_cnt=0.
  - walmost_full=1 once wlevel reaches 56.
  - After the reader drains, the data read equals 0..69 in order.
- Same stall with s_drop_en=1 and 70 samples -> 64 in FIFO, 2 buffered, drop_cnt=4, overflow_sticky=1, s_ready stays 1.
- clr_stats=1 in the same cycle as a drop, with drop_cnt=4 -> drop_cnt=1, overflow_sticky=1. Next cycle with no drop and clr_stats=1 -> both 0.
- Wrap: wptr=Gray(3), wq2_rptr=Gray(125) with ADDR_SIZE=6 -> wlevel=6. Forcing 2^16+3 drops -> drop_cnt=0xFFFF (saturated).
